// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - RV32I opcode enum, NOP constant and decoded-field struct
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui      = 7'b0110111,
    op_auipc    = 7'b0010111,
    op_jal      = 7'b1101111,
    op_jalr     = 7'b1100111,
    op_br       = 7'b1100011,
    op_load     = 7'b0000011,
    op_store    = 7'b0100011,
    op_imm      = 7'b0010011,
    op_reg      = 7'b0110011,
    op_csr      = 7'b1110011,
    op_misc_mem = 7'b0001111
  } opcode_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
    logic [31:0] imm;
    logic        illegal;
  } ir_fields_t;

  // True for every major opcode of the RV32I base set (fence included).
  function automatic logic is_rv32i_opcode(input logic [6:0] op);
    case (op)
      op_lui, op_auipc, op_jal, op_jalr, op_br, op_load,
      op_store, op_imm, op_reg, op_csr, op_misc_mem: is_rv32i_opcode = 1'b1;
      default:                                        is_rv32i_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ir_field_decode.sv
// rtl/ir_field_decode.sv - combinational RV32I field and immediate extractor
module ir_field_decode
  import rv32i_types::*;
(
  input  logic [31:0] inst_i,
  output ir_fields_t  fields_o
);

  // Slice register indices, build every immediate format, then pick one by opcode.
  always_comb begin
    fields_o         = '0;
    fields_o.opcode  = inst_i[6:0];
    fields_o.funct3  = inst_i[14:12];
    fields_o.funct7  = inst_i[31:25];
    fields_o.rs1     = inst_i[19:15];
    fields_o.rs2     = inst_i[24:20];
    fields_o.rd      = inst_i[11:7];
    fields_o.i_imm   = {{20{inst_i[31]}}, inst_i[31:20]};
    fields_o.s_imm   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    fields_o.b_imm   = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
    fields_o.u_imm   = {inst_i[31:12], 12'h000};
    fields_o.j_imm   = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
    fields_o.illegal = ~is_rv32i_opcode(inst_i[6:0]) | (inst_i[1:0] != 2'b11);
    case (inst_i[6:0])
      op_lui, op_auipc: fields_o.imm = fields_o.u_imm;
      op_jal:           fields_o.imm = fields_o.j_imm;
      op_br:            fields_o.imm = fields_o.b_imm;
      op_store:         fields_o.imm = fields_o.s_imm;
      default:          fields_o.imm = fields_o.i_imm;
    endcase
  end

endmodule

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - circular instruction/PC buffer between imem and decode
module ir_queue
  import rv32i_types::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [6:0]       opcode,
  output logic [4:0]       rs1_s,
  output logic [4:0]       rs2_s,
  output logic [4:0]       rd_s,
  output logic [31:0]      i_imm,
  output logic [31:0]      s_imm,
  output logic [31:0]      b_imm,
  output logic [31:0]      u_imm,
  output logic [31:0]      j_imm,
  output logic [31:0]      imm,
  output logic             illegal,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]    inst_mem_q [DEPTH];
  logic [31:0]    pc_mem_q   [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  ir_fields_t       head_fields;

  // Handshakes: a full buffer still accepts when the head leaves this cycle.
  // Reset also masks out_valid so nothing leaks out while the queue is dropped.
  always_comb begin
    out_valid = (count_q != '0) & ~flush & ~rst;
    in_ready  = ~rst & ~flush & ((count_q < FULL_CNT) | (out_ready & (count_q != '0)));
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Pointer and occupancy next state; reset and flush empty the buffer outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (rst || flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
    count_q  <= count_d;
  end

  // Entry storage; contents are left as-is on reset since count gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= in_inst;
      pc_mem_q[wr_ptr_q]   <= in_pc;
    end
  end

  // Head presentation: an empty or flushing buffer shows a NOP at PC 0.
  always_comb begin
    out_inst = NOP_INST;
    out_pc   = '0;
    if (out_valid) begin
      out_inst = inst_mem_q[rd_ptr_q];
      out_pc   = pc_mem_q[rd_ptr_q];
    end
  end

  ir_field_decode u_decode (
    .inst_i   (out_inst),
    .fields_o (head_fields)
  );

  // Fan the decoded head fields out to the individual ports.
  always_comb begin
    funct3  = head_fields.funct3;
    funct7  = head_fields.funct7;
    opcode  = head_fields.opcode;
    rs1_s   = head_fields.rs1;
    rs2_s   = head_fields.rs2;
    rd_s    = head_fields.rd;
    i_imm   = head_fields.i_imm;
    s_imm   = head_fields.s_imm;
    b_imm   = head_fields.b_imm;
    u_imm   = head_fields.u_imm;
    j_imm   = head_fields.j_imm;
    imm     = head_fields.imm;
    illegal = head_fields.illegal;
    count   = count_q;
  end

endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
Parametrised instruction buffer between imem response and decode. It holds up to DEPTH fetched instruction/PC pairs in a circular FIFO with valid/ready handshakes on both sides. It presents the RV32I fields of the head entry: funct3/funct7/opcode, register indices, every immediate type and one opcode-selected immediate. It supports a one-cycle flush for branch redirect.

Parameters:
DEPTH, 4, number of buffered entries; power of two, >= 2.
PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all entries (redirect)
in_valid  in  1  imem response valid
in_ready  out  1  buffer can accept this cycle
in_inst  in  32  fetched instruction word
in_pc  in  32  PC of in_inst
out_valid  out  1  head entry valid
out_ready  in  1  decode consumes head this cycle
out_inst  out  32  head instruction word
out_pc  out  32  head PC
funct3  out  3  head[14:12]
funct7  out  7  head[31:25]
opcode  out  7  head[6:0]
rs1_s, rs2_s, rd_s  out  5 each  head[19:15], head[24:20], head[11:7]
i_imm, s_imm, b_imm, u_imm, j_imm  out  32 each  sign-extended RV32I immediates of head
imm  out  32  immediate selected by opcode
illegal  out  1  head opcode not RV32I or head[1:0] != 2'b11
count  out  PTR_W+1  occupied entries

Behaviour:
- Storage: DEPTH-entry array of {inst, pc}. rd_ptr/wr_ptr wrap modulo DEPTH. count ranges 0..DEPTH.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- out_valid = (count != 0) & ~flush.
- in_ready = ~rst & ~flush & ((count < DEPTH) | (out_ready & count != 0)). When full, a same-cycle pop frees a slot, so in_ready depends combinationally on out_ready.
- Latency: a pushed entry becomes visible at the head no earlier than the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at any count >= 1.
- Decoded outputs are combinational from the head entry, so they are valid in the same cycle as out_valid.
- When out_valid=0, the head is treated as NOP 32'h0000_0013. out_pc=0 and all fields decode that NOP (illegal=0).
- Immediate formats:
  - i_imm = sext(inst[31:20])
  - s_imm = sext({inst[31:25], inst[11:7]})
  - b_imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0})
  - u_imm = {inst[31:12], 12'h000}
  - j_imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0})
- imm selection by opcode:
  - LUI/AUIPC -> u_imm
  - JAL -> j_imm
  - BR -> b_imm
  - STORE -> s_imm
  - JALR/LOAD/IMM/other -> i_imm
- flush: next cycle count=0 and rd_ptr=wr_ptr=0. Any push or pop in the flush cycle is ignored. Flush has priority over push/pop.
- rst: identical state effect to flush. Array contents need not be cleared.
- Values after reset: out_valid=0, count=0, in_ready=1 (first cycle after rst deasserts), out_inst=NOP, imm=0.
- rst asserted mid-stream drops all in-flight entries with no partial outputs.
- Assertions in the bench:
  - count never exceeds DEPTH.
  - A push when count==DEPTH without a pop is impossible.
  - Pop order equals push order (FIFO).

Decomposition:
- Shared package (rv32i_types): the opcode enum (op_lui, op_auipc, op_jal, op_jalr, op_br, op_load, op_store, op_imm, op_reg, op_csr), the NOP constant 32'h0000_0013, and a packed struct ir_fields_t holding all decoded fields.
- One combinational sub-module, ir_field_decode: 32-bit word in, ir_fields_t out (including imm and illegal). It is reused later by the decode stage.
- ir_queue holds only the FIFO, handshake and flush logic.

Test Plan:
- Reset, then push addi x1,x2,-1 (0xFFF10093, pc 0x100) -> next cycle out_valid=1, rd_s=1, rs1_s=2, funct3=0, i_imm=imm=0xFFFFFFFF, out_pc=0x100.
- Push beq x1,x2,-4 (0xFE208EE3) -> b_imm=imm=0xFFFFFFFC, rs2_s=2. Push lui x5,0x12345 (0x123452B7) -> imm=0x12345000, rd_s=5.
- DEPTH=4: push 4 with out_ready=0 -> count=4, in_ready=0. Then out_ready=1 and in_valid=1 -> in_ready=1, count stays 4, outputs in push order.
- Push 3 entries, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_inst=0x00000013, and the flush-cycle push never appears.
- Push 0x0000007F -> illegal=1. Push 0x00000010 (bits[1:0]=00) -> illegal=1.
- Random push/pop for 10k cycles against a reference queue -> identical ordered inst/pc. count matches the model every cycle and wraps pointers without loss.
